// File: rtl/scan_chain_ctrl.sv
// Scan-chain test controller: shifts a pattern in on SE/SI, runs one capture cycle, shifts the response off SO.
// Optional build macro SCAN_CMP_EN adds EXP/MISMATCH response comparison.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 CK,
  input  logic                 R,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
`ifdef SCAN_CMP_EN
  input  logic [CHAIN_LEN-1:0] EXP,
  output logic                 MISMATCH,
`endif
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP
);

  localparam int CNT_W = $clog2(CHAIN_LEN);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SHIFT_IN  = 3'd1;
  localparam logic [2:0] CAPTURE   = 3'd2;
  localparam logic [2:0] SHIFT_OUT = 3'd3;
  localparam logic [2:0] DONE_ST   = 3'd4;

  // Handshake: START acts as a valid that is consumed only while state is IDLE;
  // BUSY/DONE are status, not a ready, and START outside IDLE is dropped, never queued.
  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [CHAIN_LEN-1:0] pat_sh;
  logic [CHAIN_LEN-1:0] resp_sh;
  logic [CHAIN_LEN-1:0] resp_final;
  logic                 last;
  logic                 accept;

  assign last   = (cnt == CNT_W'(CHAIN_LEN - 1));
  assign accept = (state == IDLE) && START;

  // Response including the bit being sampled on this edge, so RESP is valid together with DONE.
  always_comb begin
    resp_final      = resp_sh;
    resp_final[cnt] = SO;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (START) state_nxt = SHIFT_IN;
      end
      SHIFT_IN: begin
        if (last) state_nxt = CAPTURE;
        else      cnt_nxt   = cnt + CNT_W'(1);
      end
      CAPTURE: begin
        state_nxt = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        if (last) state_nxt = DONE_ST;
        else      cnt_nxt   = cnt + CNT_W'(1);
      end
      DONE_ST: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CK) begin
    if (R) begin
      state   <= IDLE;
      cnt     <= '0;
      pat_sh  <= '0;
      resp_sh <= '0;
      SE      <= 1'b0;
      SI      <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RESP    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      SE    <= (state_nxt == SHIFT_IN) || (state_nxt == SHIFT_OUT);
      BUSY  <= (state_nxt == SHIFT_IN) || (state_nxt == CAPTURE) ||
               (state_nxt == SHIFT_OUT);
      DONE  <= (state_nxt == DONE_ST);
      SI    <= 1'b0;
      if (accept) begin
        SI     <= PAT[0];
        pat_sh <= PAT >> 1;
      end else if ((state == SHIFT_IN) && !last) begin
        SI     <= pat_sh[0];
        pat_sh <= pat_sh >> 1;
      end
      if (state == SHIFT_OUT) begin
        resp_sh[cnt] <= SO;
        if (last) RESP <= resp_final;
      end
    end
  end

`ifdef SCAN_CMP_EN
  logic [CHAIN_LEN-1:0] exp_lat;

  always_ff @(posedge CK) begin
    if (R) begin
      exp_lat  <= '0;
      MISMATCH <= 1'b0;
    end else if (accept) begin
      exp_lat  <= EXP;
      MISMATCH <= 1'b0;
    end else if ((state == SHIFT_OUT) && last) begin
      MISMATCH <= (resp_final != exp_lat);
    end
  end
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with a 4-cell SDFF chain (D = ~Q) closing the loop from SE/SI back to SO.
module tb_scan_chain_ctrl;

  localparam int N = 4;

  logic         ck = 1'b0;
  logic         r;
  logic         start;
  logic [N-1:0] pat;
  logic         so;
  logic         se;
  logic         si;
  logic         busy;
  logic         done;
  logic [N-1:0] resp;
`ifdef SCAN_CMP_EN
  logic [N-1:0] exp_v;
  logic         mismatch;
`endif

  logic [N-1:0] chain_q = '0;
  logic [N-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 ck = ~ck;

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .CK(ck),
    .R(r),
    .START(start),
    .PAT(pat),
`ifdef SCAN_CMP_EN
    .EXP(exp_v),
    .MISMATCH(mismatch),
`endif
    .SO(so),
    .SE(se),
    .SI(si),
    .BUSY(busy),
    .DONE(done),
    .RESP(resp)
  );

  // Scan chain: cell 0 takes SI, cell N-1 drives SO; functional D is ~Q.
  always_ff @(posedge ck) begin
    if (se) chain_q <= {chain_q[N-2:0], si};
    else    chain_q <= ~chain_q;
  end
  assign so = chain_q[N-1];

  // Reference model, in cycles counted from the accept edge (cycle 1 = first cycle after it).
  function automatic logic exp_se(input int c);
    return ((c >= 1) && (c <= N)) || ((c >= N + 2) && (c <= 2 * N + 1));
  endfunction

  function automatic logic exp_si(input logic [N-1:0] p, input int c);
    if ((c >= 1) && (c <= N)) return p[c-1];
    return 1'b0;
  endfunction

  function automatic logic exp_busy(input int c);
    return (c >= 1) && (c <= 2 * N + 1);
  endfunction

  function automatic logic exp_done(input int c);
    return c == 2 * N + 2;
  endfunction

  // Chain ends with PAT[0] next to SO; capture inverts each cell; RESP[k] is the k-th bit off SO.
  function automatic logic [N-1:0] model_resp(input logic [N-1:0] p);
    logic [N-1:0] cells;
    logic [N-1:0] out;
    for (int k = 0; k < N; k++) cells[N-1-k] = p[k];
    cells = ~cells;
    for (int k = 0; k < N; k++) out[k] = cells[N-1-k];
    return out;
  endfunction

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    r = 1'b1;
    start = 1'b0;
    pat = '0;
`ifdef SCAN_CMP_EN
    exp_v = '0;
`endif
    step();
    step();
    r = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({se, si, busy, done} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_ctrl i=%0d got se,si,busy,done=%b want 0000", i, {se, si, busy, done});
      end
      n_checks++;
      if (resp !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_resp i=%0d got %b want 0000", i, resp);
      end
`ifdef SCAN_CMP_EN
      n_checks++;
      if (mismatch !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mismatch got %b want 0", mismatch);
      end
`endif
      step();
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] p;
    logic [N-1:0] want;
    int           busy_cnt;
    p = 4'b0011;
    busy_cnt = 0;
    want = 'x;
    pat = p;
    start = 1'b1;
    exp_q.push_back(model_resp(p));
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      n_checks++;
      if ({se, si} !== {exp_se(c), exp_si(p, c)}) begin
        n_fail++;
        $display("FAIL basic_se_si c=%0d got %b want %b", c, {se, si}, {exp_se(c), exp_si(p, c)});
      end
      n_checks++;
      if ({busy, done} !== {exp_busy(c), exp_done(c)}) begin
        n_fail++;
        $display("FAIL basic_busy_done c=%0d got %b want %b", c, {busy, done}, {exp_busy(c), exp_done(c)});
      end
      if (exp_done(c)) want = exp_q.pop_front();
      if (c >= 2 * N + 2) begin
        n_checks++;
        if (resp !== want) begin
          n_fail++;
          $display("FAIL basic_resp c=%0d got %b want %b", c, resp, want);
        end
      end
    end
    n_checks++;
    if (busy_cnt != 2 * N + 1) begin
      n_fail++;
      $display("FAIL basic_busy_len got %0d want %0d", busy_cnt, 2 * N + 1);
    end
  endtask

  task automatic test_ignored_start();
    logic [N-1:0] p;
    int           dones;
    p = 4'b0101;
    dones = 0;
    pat = p;
    start = 1'b1;
    exp_q.push_back(model_resp(p));
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (c == 2) pat = N'($urandom);
      if (c == 7) start = 1'b1;
      if (c == 8) start = 1'b0;
      if (done === 1'b1) dones++;
      n_checks++;
      if (se !== exp_se(c)) begin
        n_fail++;
        $display("FAIL ignored_se c=%0d got %b want %b", c, se, exp_se(c));
      end
      if (exp_done(c)) begin
        n_checks++;
        if (resp !== exp_q[0]) begin
          n_fail++;
          $display("FAIL ignored_resp got %b want %b", resp, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL ignored_done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] p;
    int           last_done;
    int           dones;
    logic         w_se;
    logic         w_done;
    p = 4'b1111;
    last_done = -1;
    dones = 0;
    pat = p;
    start = 1'b1;
    exp_q.push_back(model_resp(p));
    exp_q.push_back(model_resp(p));
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c == 22) start = 1'b0;
      w_se   = exp_se(c) || exp_se(c - 11);
      w_done = exp_done(c) || exp_done(c - 11);
      n_checks++;
      if ({se, done} !== {w_se, w_done}) begin
        n_fail++;
        $display("FAIL b2b_se_done c=%0d got %b want %b", c, {se, done}, {w_se, w_done});
      end
      if (done === 1'b1) begin
        dones++;
        if (last_done >= 0) begin
          n_checks++;
          if (c - last_done != 2 * N + 3) begin
            n_fail++;
            $display("FAIL b2b_gap got %0d want %0d", c - last_done, 2 * N + 3);
          end
        end
        last_done = c;
        if (exp_q.size() > 0) begin
          n_checks++;
          if (resp !== exp_q[0]) begin
            n_fail++;
            $display("FAIL b2b_resp c=%0d got %b want %b", c, resp, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
    end
    n_checks++;
    if (dones != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count got %0d want 2", dones);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] p;
    int           gap;
    int           ign;
    for (int it = 0; it < 8; it++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        pat = N'($urandom);
        step();
      end
      p = N'($urandom_range(0, 14));
      ign = $urandom_range(2, 10);
      pat = p;
      start = 1'b1;
      exp_q.push_back(model_resp(p));
      for (int c = 1; c <= 2 * N + 3; c++) begin
        step();
        if (c == 1) begin
          start = 1'b0;
          pat = N'($urandom);
        end
        if (c == ign) start = 1'b1;
        if (c == ign + 1) start = 1'b0;
        n_checks++;
        if ({se, si, busy, done} !== {exp_se(c), exp_si(p, c), exp_busy(c), exp_done(c)}) begin
          n_fail++;
          $display("FAIL rand_ctrl it=%0d c=%0d pat=%b got %b want %b", it, c, p,
                   {se, si, busy, done}, {exp_se(c), exp_si(p, c), exp_busy(c), exp_done(c)});
        end
        if (exp_done(c)) begin
          n_checks++;
          if (resp !== exp_q[0]) begin
            n_fail++;
            $display("FAIL rand_resp it=%0d pat=%b got %b want %b", it, p, resp, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] p;
    p = N'($urandom);
    pat = p;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (c == 2) r = 1'b1;
      if (c == 3) r = 1'b0;
      if (c >= 3) begin
        n_checks++;
        if ({se, si, busy, done} !== 4'b0000) begin
          n_fail++;
          $display("FAIL rstmid_ctrl c=%0d got %b want 0000", c, {se, si, busy, done});
        end
        n_checks++;
        if (resp !== 4'h0) begin
          n_fail++;
          $display("FAIL rstmid_resp c=%0d got %b want 0000", c, resp);
        end
      end
    end
    p = N'($urandom);
    pat = p;
    start = 1'b1;
    exp_q.push_back(model_resp(p));
    for (int c = 1; c <= 2 * N + 3; c++) begin
      step();
      if (c == 1) start = 1'b0;
      n_checks++;
      if ({se, si, done} !== {exp_se(c), exp_si(p, c), exp_done(c)}) begin
        n_fail++;
        $display("FAIL rstmid_rerun c=%0d got %b want %b", c, {se, si, done}, {exp_se(c), exp_si(p, c), exp_done(c)});
      end
      if (exp_done(c)) begin
        n_checks++;
        if (resp !== exp_q[0]) begin
          n_fail++;
          $display("FAIL rstmid_rerun_resp got %b want %b", resp, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  endtask

`ifdef SCAN_CMP_EN
  task automatic test_compare();
    logic [N-1:0] exps[3];
    logic         want;
    exps[0] = 4'b1100;
    exps[1] = 4'b1101;
    exps[2] = 4'b1100;
    for (int run = 0; run < 3; run++) begin
      pat = 4'b0011;
      exp_v = exps[run];
      start = 1'b1;
      want = (model_resp(4'b0011) != exps[run]);
      for (int c = 1; c <= 2 * N + 6; c++) begin
        step();
        if (c == 1) begin
          start = 1'b0;
          exp_v = ~exps[run];
        end
        if (c == 1) begin
          n_checks++;
          if (mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_clear run=%0d got %b want 0", run, mismatch);
          end
        end
        if (c >= 2 * N + 2) begin
          n_checks++;
          if (mismatch !== want) begin
            n_fail++;
            $display("FAIL cmp_mismatch run=%0d c=%0d got %b want %b", run, c, mismatch, want);
          end
        end
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_ignored_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef SCAN_CMP_EN
    test_compare();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
